rxd_deserializer: RTL and testbench
===================================

Name: rxd_deserializer

Overview:
Parametrised serial-to-parallel assembler for the UART/serial receive path. It sits between the receiver's bit-sampling FSM and the byte consumer. It accepts one sampled bit per `bit_en` strobe and writes it into a bit position chosen by an internal counter. When the frame completes it presents the word with a ready/acknowledge handshake, and it reports framing-restart and overrun errors.

Parameters:
- DATA_W, 8: data bits per frame, legal range 2..32.
- MSB_FIRST, 0: bit ordering. 0 means the first received bit lands in data[0]. 1 means it lands in data[DATA_W-1].
- IDX_W, $clog2(DATA_W+1): localparam, width of the bit counter. Not overridable.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: begins a new frame. Asserted by the sampler on the detected start bit.
- bit_en, input, 1: one-cycle strobe meaning `rxd` holds a valid sampled bit.
- rxd, input, 1: sampled serial bit.
- abort, input, 1: discards the frame in progress.
- ack, input, 1: consumer has taken `data`.
- data, output, DATA_W: assembled word, held stable until the next completion.
- data_valid, output, 1: one-cycle pulse on completion.
- rdy, output, 1: word available, not yet acknowledged.
- busy, output, 1: frame in progress.
- bit_idx, output, IDX_W: number of bits received in the current frame.
- frame_err, output, 1: one-cycle pulse when `start` arrives mid-frame.
- overrun, output, 1: one-cycle pulse when a completion occurs while `rdy` is high.
- parity_err, output, 1: see Optional Feature.

Behaviour:
- Reset (`rst` high at a clk edge): state goes to IDLE. data=0, shadow=0, bit_idx=0. data_valid, rdy, busy, frame_err, overrun and parity_err are all 0. Reset overrides every other input, including mid-frame, and an in-progress frame is lost silently.
- States:
  - IDLE: `busy`=0. `start` → SHIFT with shadow cleared and bit_idx=0. `bit_en` is ignored.
  - SHIFT: `busy`=1. Each `bit_en` writes rxd into shadow[pos] and increments bit_idx.
    - pos = bit_idx when MSB_FIRST=0; pos = DATA_W-1-bit_idx when MSB_FIRST=1.
  - Completion: the `bit_en` with bit_idx==DATA_W-1 completes the frame. At that same edge:
    - data ← shadow with the final bit merged in;
    - rdy ← 1;
    - state → IDLE;
    - bit_idx ← 0.
  - data_valid is high for exactly the cycle after that edge. Latency is 1 clk from the final `bit_en` cycle to data/data_valid visible.
- Handshake:
  - `rdy` stays high until `ack` is sampled high, then clears on the next edge.
  - `ack` while `rdy`=0 has no effect.
  - Completion in the same cycle as `ack`: `rdy` stays 1 (new word), no overrun.
  - Completion while `rdy`=1 and `ack`=0: data is overwritten, `rdy` stays 1, and `overrun` pulses with the same timing as data_valid.
- Priority in SHIFT: abort > start > bit_en.
  - abort: go to IDLE, bit_idx=0, no data_valid, and data/rdy are unchanged.
  - start: restart the frame (shadow cleared, bit_idx=0, stay in SHIFT). The simultaneous bit is discarded and `frame_err` pulses the next cycle.
- abort in IDLE is a no-op. start+abort in IDLE stays in IDLE.
- Outputs are registered. No combinational path from inputs to outputs.

Optional Feature:
- Macro: RXD_PARITY_CHECK_EN.
- Defined:
  - A frame is DATA_W data bits followed by one even-parity bit, received as one extra `bit_en`. Completion occurs on that extra bit (bit_idx==DATA_W), and the parity bit is not stored in `data`.
  - `parity_err` is a registered level, valid while `rdy`=1. It is 1 if the XOR of the data bits and the parity bit is 1, and it updates on each completion.
  - data_valid and the handshake are unchanged. Words with bad parity are still delivered.
- Undefined: the port exists but is tied to 0, and frames are DATA_W bits.

Decomposition:
- Package rxd_pkg:
  - typedef enum logic [1:0] {IDLE, SHIFT} rx_state_t;
  - function bit_pos(idx, msb_first) returning the target index.
- One natural sub-module: rxd_bit_writer. It is combinational: (shadow, pos, rxd, we) → next shadow. It generalises the 3-to-8 bit-steering decoder to DATA_W.
- The FSM, counter and handshake stay in the top module.

Test Plan:
- DATA_W=8, MSB_FIRST=0: start, then bits 1,0,1,1,0,0,1,0 with `bit_en` every 4 clks → data=8'h4D, data_valid one cycle after the last bit_en, rdy=1 until ack.
- Same bits with MSB_FIRST=1 → data=8'hB2. bit_idx steps 0..7 and then returns to 0.
- Send 8'h4D without ack, then a second frame 8'hFF → data=8'hFF, overrun pulses once, rdy stays 1. Ack → rdy=0 the next cycle.
- start, 3 bits, then start+bit_en in the same cycle → frame_err pulse, bit_idx=0. The following 8 bits assemble correctly. abort after 5 bits → no data_valid, and data/rdy keep their previous values.
- rst asserted after 4 bits → all outputs 0 next cycle. A fresh frame afterwards completes normally. DATA_W=5 with bits 1,1,0,0,1 → data=5'b10011.
- With RXD_PARITY_CHECK_EN: 8'h4D (4 ones) + parity 0 → parity_err=0. Same data + parity 1 → parity_err=1, and data is still 8'h4D with data_valid pulsing.

Source files
------------

// File: rtl/rxd_deserializer_pkg.sv
// rtl/rxd_deserializer_pkg.sv - shared types and bit-position helper for the rxd deserializer
package rxd_pkg;

  // Frame-assembly states: waiting for a start bit, or shifting data bits in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } rx_state_t;

  // Maps the running bit count to the word position that bit belongs in.
  function automatic int bit_pos(input int idx, input int data_w, input bit msb_first);
    return msb_first ? (data_w - 1 - idx) : idx;
  endfunction

endpackage

// File: rtl/rxd_deserializer_if.sv
// rtl/rxd_deserializer_if.sv - assembled-word output handshake (data/data_valid/rdy/ack)
interface rxd_deserializer_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] data;
  logic              data_valid;
  logic              rdy;
  logic              ack;

  // The deserializer produces words; the byte consumer acknowledges them.
  modport master (
    output data,
    output data_valid,
    output rdy,
    input  ack
  );

  modport slave (
    input  data,
    input  data_valid,
    input  rdy,
    output ack
  );

endinterface

// File: rtl/rxd_deserializer_bit_writer.sv
// rtl/rxd_deserializer_bit_writer.sv - steers one received bit into a DATA_W-wide shadow word
module rxd_bit_writer #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = $clog2(DATA_W + 1)
) (
  input  logic [DATA_W-1:0] shadow,
  input  logic [IDX_W-1:0]  pos,
  input  logic              rxd,
  input  logic              we,
  output logic [DATA_W-1:0] shadow_next
);

  logic [DATA_W-1:0] sel;

  // One-hot position decode; out-of-range positions select nothing.
  always_comb begin
    sel = '0;
    for (int i = 0; i < DATA_W; i++) begin
      sel[i] = we && (pos == IDX_W'(i));
    end
  end

  // Replace only the selected bit, keep the rest of the shadow word.
  always_comb begin
    shadow_next = shadow;
    for (int i = 0; i < DATA_W; i++) begin
      if (sel[i]) begin
        shadow_next[i] = rxd;
      end
    end
  end

endmodule

// File: rtl/rxd_deserializer.sv
// rtl/rxd_deserializer.sv - serial-to-parallel frame assembler; RXD_PARITY_CHECK_EN adds an even-parity bit
module rxd_deserializer
  import rxd_pkg::*;
#(
  parameter int   DATA_W    = 8,
  parameter int   MSB_FIRST = 0,
  localparam int  IDX_W     = $clog2(DATA_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_en,
  input  logic             rxd,
  input  logic             abort,
  rxd_deserializer_if.master out_if,
  output logic             busy,
  output logic [IDX_W-1:0] bit_idx,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err
);

`ifdef RXD_PARITY_CHECK_EN
  // The parity bit arrives as one extra strobe after the data bits.
  localparam int LAST_IDX = DATA_W;
`else
  localparam int LAST_IDX = DATA_W - 1;
`endif

  rx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic              rdy_q, rdy_d;
  logic              data_valid_q, data_valid_d;
  logic              busy_q, busy_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
`ifdef RXD_PARITY_CHECK_EN
  logic              par_acc_q, par_acc_d;
  logic              parity_err_q, parity_err_d;
`endif

  logic              we;
  logic [IDX_W-1:0]  pos;
  logic [DATA_W-1:0] shadow_next;

  assign pos = IDX_W'(bit_pos(int'(bit_idx_q), DATA_W, MSB_FIRST != 0));

  rxd_bit_writer #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_bit_writer (
    .shadow      (shadow_q),
    .pos         (pos),
    .rxd         (rxd),
    .we          (we),
    .shadow_next (shadow_next)
  );

  // Next-state: frame control (abort > start > bit_en), counter, and word handshake.
  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    data_d       = data_q;
    bit_idx_d    = bit_idx_q;
    rdy_d        = rdy_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    we           = 1'b0;
`ifdef RXD_PARITY_CHECK_EN
    par_acc_d    = par_acc_q;
    parity_err_d = parity_err_q;
`endif

    // A pending ack clears rdy unless a completion below re-asserts it.
    if (rdy_q && out_if.ack) begin
      rdy_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = SHIFT;
          shadow_d  = '0;
          bit_idx_d = '0;
`ifdef RXD_PARITY_CHECK_EN
          par_acc_d = 1'b0;
`endif
        end
      end

      SHIFT: begin
        if (abort) begin
          state_d   = IDLE;
          bit_idx_d = '0;
        end else if (start) begin
          shadow_d    = '0;
          bit_idx_d   = '0;
          frame_err_d = 1'b1;
`ifdef RXD_PARITY_CHECK_EN
          par_acc_d   = 1'b0;
`endif
        end else if (bit_en) begin
          // The parity strobe (index DATA_W) is counted but never stored.
          we       = (int'(bit_idx_q) < DATA_W);
          shadow_d = shadow_next;
`ifdef RXD_PARITY_CHECK_EN
          par_acc_d = par_acc_q ^ rxd;
`endif
          if (bit_idx_q == IDX_W'(LAST_IDX)) begin
            state_d      = IDLE;
            bit_idx_d    = '0;
            data_d       = shadow_next;
            data_valid_d = 1'b1;
            overrun_d    = rdy_q && !out_if.ack;
            rdy_d        = 1'b1;
`ifdef RXD_PARITY_CHECK_EN
            parity_err_d = par_acc_q ^ rxd;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end

      default: begin
        state_d   = IDLE;
        bit_idx_d = '0;
      end
    endcase

    busy_d = (state_d == SHIFT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      data_q       <= '0;
      bit_idx_q    <= '0;
      rdy_q        <= 1'b0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef RXD_PARITY_CHECK_EN
      par_acc_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      data_q       <= data_d;
      bit_idx_q    <= bit_idx_d;
      rdy_q        <= rdy_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef RXD_PARITY_CHECK_EN
      par_acc_q    <= par_acc_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign out_if.data       = data_q;
  assign out_if.data_valid = data_valid_q;
  assign out_if.rdy        = rdy_q;
  assign busy              = busy_q;
  assign bit_idx           = bit_idx_q;
  assign frame_err         = frame_err_q;
  assign overrun           = overrun_q;
`ifdef RXD_PARITY_CHECK_EN
  assign parity_err        = parity_err_q;
`else
  assign parity_err        = 1'b0;
`endif

endmodule

// File: tb/tb_rxd_deserializer.sv
// tb/tb_rxd_deserializer.sv - self-checking bench for rxd_deserializer (three parameter sets, RXD_PARITY_CHECK_EN aware)
module tb_rxd_deserializer;

`ifdef RXD_PARITY_CHECK_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk = 1'b0;
  logic rst, start, bit_en, rxd, abort, ack;
  always #5 clk = ~clk;

  rxd_deserializer_if #(.DATA_W(8)) if0 ();
  rxd_deserializer_if #(.DATA_W(8)) if1 ();
  rxd_deserializer_if #(.DATA_W(5)) if2 ();
  assign if0.ack = ack;
  assign if1.ack = ack;
  assign if2.ack = ack;

  logic       busy0, busy1, busy2, fe0, fe1, fe2, ov0, ov1, ov2, pe0, pe1, pe2;
  logic [3:0] idx0, idx1;
  logic [2:0] idx2;

  rxd_deserializer #(.DATA_W(8), .MSB_FIRST(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .bit_en(bit_en), .rxd(rxd), .abort(abort),
    .out_if(if0), .busy(busy0), .bit_idx(idx0), .frame_err(fe0), .overrun(ov0), .parity_err(pe0));
  rxd_deserializer #(.DATA_W(8), .MSB_FIRST(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .bit_en(bit_en), .rxd(rxd), .abort(abort),
    .out_if(if1), .busy(busy1), .bit_idx(idx1), .frame_err(fe1), .overrun(ov1), .parity_err(pe1));
  rxd_deserializer #(.DATA_W(5), .MSB_FIRST(0)) dut2 (
    .clk(clk), .rst(rst), .start(start), .bit_en(bit_en), .rxd(rxd), .abort(abort),
    .out_if(if2), .busy(busy2), .bit_idx(idx2), .frame_err(fe2), .overrun(ov2), .parity_err(pe2));

  logic [31:0] o_data[3], o_idx[3];
  logic        o_dv[3], o_rdy[3], o_busy[3], o_fe[3], o_ov[3], o_pe[3];
  assign o_data[0] = 32'(if0.data); assign o_data[1] = 32'(if1.data); assign o_data[2] = 32'(if2.data);
  assign o_idx[0] = 32'(idx0); assign o_idx[1] = 32'(idx1); assign o_idx[2] = 32'(idx2);
  assign o_dv[0] = if0.data_valid; assign o_dv[1] = if1.data_valid; assign o_dv[2] = if2.data_valid;
  assign o_rdy[0] = if0.rdy; assign o_rdy[1] = if1.rdy; assign o_rdy[2] = if2.rdy;
  assign o_busy[0] = busy0; assign o_busy[1] = busy1; assign o_busy[2] = busy2;
  assign o_fe[0] = fe0; assign o_fe[1] = fe1; assign o_fe[2] = fe2;
  assign o_ov[0] = ov0; assign o_ov[1] = ov1; assign o_ov[2] = ov2;
  assign o_pe[0] = pe0; assign o_pe[1] = pe1; assign o_pe[2] = pe2;

  // Reference model: list of bits received so far per configuration.
  int          cfg_w[3] = '{8, 8, 5};
  bit          cfg_m[3] = '{1'b0, 1'b1, 1'b0};
  bit          m_inf[3];
  int          m_cnt[3];
  bit          m_acc[3][40];
  logic [31:0] m_data[3];
  bit          m_rdy[3], m_dv[3], m_fe[3], m_ov[3], m_pe[3];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit prev_rdy;
      if (rst) begin
        m_inf[k] = 0; m_cnt[k] = 0; m_data[k] = '0; m_rdy[k] = 0;
        m_dv[k] = 0; m_fe[k] = 0; m_ov[k] = 0; m_pe[k] = 0;
        continue;
      end
      m_dv[k] = 0; m_fe[k] = 0; m_ov[k] = 0;
      prev_rdy = m_rdy[k];
      if (prev_rdy && ack) m_rdy[k] = 0;
      if (!m_inf[k]) begin
        if (start && !abort) begin m_inf[k] = 1; m_cnt[k] = 0; end
      end else if (abort) begin
        m_inf[k] = 0; m_cnt[k] = 0;
      end else if (start) begin
        m_cnt[k] = 0; m_fe[k] = 1;
      end else if (bit_en) begin
        m_acc[k][m_cnt[k]] = rxd;
        m_cnt[k]++;
        if (m_cnt[k] == cfg_w[k] + PB) begin
          logic [31:0] word;
          bit p;
          word = '0;
          p = 0;
          for (int j = 0; j < cfg_w[k]; j++) begin
            if (cfg_m[k]) word[cfg_w[k]-1-j] = m_acc[k][j];
            else          word[j] = m_acc[k][j];
          end
          for (int j = 0; j < cfg_w[k] + PB; j++) p ^= m_acc[k][j];
          m_data[k] = word;
          m_dv[k] = 1;
          m_ov[k] = prev_rdy && !ack;
          m_rdy[k] = 1;
          if (PB != 0) m_pe[k] = p;
          m_inf[k] = 0;
          m_cnt[k] = 0;
        end
      end
    end
  endtask

  // Applies one cycle of inputs, advances the model, and checks every output.
  task automatic cyc(input bit r, input bit s, input bit b, input bit d, input bit a, input bit k_ack);
    rst = r; start = s; bit_en = b; rxd = d; abort = a; ack = k_ack;
    @(posedge clk);
    model_step();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d%0d_data", k), o_data[k], m_data[k]);
      chk($sformatf("d%0d_dv", k), 32'(o_dv[k]), 32'(m_dv[k]));
      chk($sformatf("d%0d_rdy", k), 32'(o_rdy[k]), 32'(m_rdy[k]));
      chk($sformatf("d%0d_busy", k), 32'(o_busy[k]), 32'(m_inf[k]));
      chk($sformatf("d%0d_idx", k), o_idx[k], 32'(m_cnt[k]));
      chk($sformatf("d%0d_fe", k), 32'(o_fe[k]), 32'(m_fe[k]));
      chk($sformatf("d%0d_ov", k), 32'(o_ov[k]), 32'(m_ov[k]));
      chk($sformatf("d%0d_pe", k), 32'(o_pe[k]), 32'(m_pe[k]));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  // Start strobe, then each bit (LSB of vec first) after a 3-cycle gap; ends on the final bit edge.
  task automatic send_bits(input logic [39:0] vec, input int n, input bit with_start);
    if (with_start) cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      idle(3);
      cyc(0, 0, 1, vec[i], 0, 0);
    end
  endtask

  initial begin
    logic [39:0] v;
    rst = 1; start = 0; bit_en = 0; rxd = 0; abort = 0; ack = 0;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 0, 1);
    chk("reset_data", o_data[0], 32'h0);
    chk("reset_rdy", 32'(o_rdy[0]), 32'h0);
    idle(2);

    // 8'h4D LSB-first / B2 MSB-first; parity bit 0 when enabled.
    v = {31'b0, 1'b0, 8'h4D};
    send_bits(v, 8 + PB, 1);
    chk("lsb_4d", o_data[0], 32'h4D);
    chk("msb_b2", o_data[1], 32'hB2);
    chk("lsb_dv", 32'(o_dv[0]), 32'h1);
    chk("pe_good", 32'(o_pe[0]), 32'h0);
    idle(3);
    chk("dv_gone", 32'(o_dv[0]), 32'h0);
    chk("rdy_held", 32'(o_rdy[0]), 32'h1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("ack_clears", 32'(o_rdy[0]), 32'h0);

    // Overrun: second word arrives without an ack.
    send_bits(v, 8 + PB, 1);
    v = {31'b0, 1'b0, 8'hFF};
    send_bits(v, 8 + PB, 1);
    chk("ovr_data", o_data[0], 32'hFF);
    chk("ovr_pulse", 32'(o_ov[0]), 32'h1);
    chk("ovr_rdy", 32'(o_rdy[0]), 32'h1);
    idle(1);
    chk("ovr_once", 32'(o_ov[0]), 32'h0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("ovr_ack", 32'(o_rdy[0]), 32'h0);

    // Restart mid-frame with a simultaneous bit.
    send_bits(40'h5, 3, 1);
    cyc(0, 1, 1, 1, 0, 0);
    chk("fe_idx", o_idx[0], 32'h0);
    idle(1);
    chk("fe_once", 32'(o_fe[0]), 32'h0);
    v = {31'b0, 1'b1, 8'h3C};
    send_bits(v, 8 + PB, 0);
    chk("after_fe", o_data[0], 32'h3C);

    // Abort after 5 bits leaves data/rdy alone.
    send_bits(40'h1F, 5, 1);
    cyc(0, 0, 0, 0, 1, 0);
    chk("abort_data", o_data[0], 32'h3C);
    chk("abort_dv", 32'(o_dv[0]), 32'h0);
    chk("abort_idle", 32'(o_busy[0]), 32'h0);
    cyc(0, 0, 0, 0, 0, 1);

    // Reset mid-frame, then a fresh frame.
    send_bits(40'hF, 4, 1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_busy", 32'(o_busy[0]), 32'h0);
    chk("rst_data", o_data[0], 32'h0);
    chk("rst_idx", o_idx[0], 32'h0);
    v = {31'b0, 1'b1, 8'hA7};
    send_bits(v, 8 + PB, 1);
    chk("post_rst", o_data[0], 32'hA7);

    // DATA_W=5: bits 1,1,0,0,1 -> 5'b10011 (parity bit 1 when enabled).
    send_bits({34'b0, 1'b1, 5'b10011}, 5 + PB, 1);
    chk("w5_data", o_data[2], 32'h13);
    chk("w5_dv", 32'(o_dv[2]), 32'h1);
    cyc(0, 0, 0, 0, 1, 1);

`ifdef RXD_PARITY_CHECK_EN
    send_bits({31'b0, 1'b1, 8'h4D}, 9, 1);
    chk("pe_bad", 32'(o_pe[0]), 32'h1);
    chk("pe_bad_data", o_data[0], 32'h4D);
    chk("pe_bad_dv", 32'(o_dv[0]), 32'h1);
    cyc(0, 0, 0, 0, 0, 1);
`endif

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 299) == 0),
          ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 59) == 0),
          ($urandom_range(0, 5) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
